// File: rtl/ddr3_arbiter.sv
// Two-master arbiter in front of the DDR3 word port; an ID FIFO steers read returns back in order.
// Define DDR3_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (m0).
module ddr3_arbiter #(
  parameter int unsigned ID_FIFO_DEPTH_BITS = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  output logic        m0_ready,
  input  logic [26:2] m0_addr,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write_req,
  input  logic        m0_read_req,
  output logic [31:0] m0_read_data,
  output logic        m0_read_data_valid,

  output logic        m1_ready,
  input  logic [26:2] m1_addr,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write_req,
  input  logic        m1_read_req,
  output logic [31:0] m1_read_data,
  output logic        m1_read_data_valid,

  input  logic        ddr_ready,
  output logic [26:2] ddr_addr,
  output logic [31:0] ddr_write_data,
  output logic [3:0]  ddr_byte_enable,
  output logic        ddr_write_req,
  output logic        ddr_read_req,
  input  logic [31:0] ddr_read_data,
  input  logic        ddr_read_data_valid,

  output logic        error
);

  localparam int unsigned Depth = 2 ** ID_FIFO_DEPTH_BITS;
  localparam logic [ID_FIFO_DEPTH_BITS:0] FullCount = {1'b1, {ID_FIFO_DEPTH_BITS{1'b0}}};

  logic                          id_mem_q [Depth];
  logic [ID_FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ID_FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ID_FIFO_DEPTH_BITS:0]   count_q, count_d;
  logic                          error_q, error_d;

  logic fifo_full, fifo_empty, head_id;
  logic elig0, elig1, gnt_valid, gnt_id;
  logic push, pop;

  assign fifo_full  = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);
  assign head_id    = id_mem_q[rd_ptr_q];

  // Reads need a free ID slot; the registered full flag is used even if a pop is in flight.
  assign elig0 = m0_write_req || (m0_read_req && !fifo_full);
  assign elig1 = m1_write_req || (m1_read_req && !fifo_full);
  assign gnt_valid = elig0 || elig1;

`ifdef DDR3_ARBITER_ROUND_ROBIN_EN
  logic last_q, last_d;
  logic accept;

  always_comb begin
    gnt_id = elig1;
    if (elig0 && elig1) begin
      gnt_id = ~last_q;
    end
  end

  assign accept = gnt_valid && ddr_ready;
  assign last_d = accept ? gnt_id : last_q;

  // Reset to 1 so master 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign gnt_id = elig1 && !elig0;
`endif

  // With no grant the master 0 fields pass through but both request strobes stay low.
  assign ddr_addr        = gnt_id ? m1_addr        : m0_addr;
  assign ddr_write_data  = gnt_id ? m1_write_data  : m0_write_data;
  assign ddr_byte_enable = gnt_id ? m1_byte_enable : m0_byte_enable;
  assign ddr_write_req   = gnt_valid && (gnt_id ? m1_write_req : m0_write_req);
  assign ddr_read_req    = gnt_valid && (gnt_id ? m1_read_req  : m0_read_req);

  assign m0_ready = gnt_valid && !gnt_id && ddr_ready;
  assign m1_ready = gnt_valid &&  gnt_id && ddr_ready;

  assign push = ddr_read_req && ddr_ready;
  assign pop  = ddr_read_data_valid && !fifo_empty;

  assign m0_read_data       = ddr_read_data;
  assign m1_read_data       = ddr_read_data;
  assign m0_read_data_valid = pop && !head_id;
  assign m1_read_data_valid = pop &&  head_id;
  assign error              = error_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q || (ddr_read_data_valid && fifo_empty);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // ID storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem_q[wr_ptr_q] <= gnt_id;
    end
  end

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Bench for ddr3_arbiter: a vector table for request arbitration plus scoreboarded read returns.
// Works with or without DDR3_ARBITER_ROUND_ROBIN_EN defined.
module tb_ddr3_arbiter;

`ifdef DDR3_ARBITER_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  localparam logic [26:2] A0 = 25'h100;
  localparam logic [26:2] A1 = 25'h200;
  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_ready, m1_ready;
  logic [26:2] m0_addr, m1_addr;
  logic [31:0] m0_write_data, m1_write_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_write_req, m0_read_req, m1_write_req, m1_read_req;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_read_data_valid, m1_read_data_valid;
  logic        ddr_ready;
  logic [26:2] ddr_addr;
  logic [31:0] ddr_write_data;
  logic [3:0]  ddr_byte_enable;
  logic        ddr_write_req, ddr_read_req;
  logic [31:0] ddr_read_data;
  logic        ddr_read_data_valid;
  logic        error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        m0_wr, m0_rd, m1_wr, m1_rd, rdy;
    logic        exp_r0, exp_r1, exp_wr, exp_rd;
    logic [26:2] exp_addr;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  ddr3_arbiter #(.ID_FIFO_DEPTH_BITS(4)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .m0_ready            (m0_ready),
    .m0_addr             (m0_addr),
    .m0_write_data       (m0_write_data),
    .m0_byte_enable      (m0_byte_enable),
    .m0_write_req        (m0_write_req),
    .m0_read_req         (m0_read_req),
    .m0_read_data        (m0_read_data),
    .m0_read_data_valid  (m0_read_data_valid),
    .m1_ready            (m1_ready),
    .m1_addr             (m1_addr),
    .m1_write_data       (m1_write_data),
    .m1_byte_enable      (m1_byte_enable),
    .m1_write_req        (m1_write_req),
    .m1_read_req         (m1_read_req),
    .m1_read_data        (m1_read_data),
    .m1_read_data_valid  (m1_read_data_valid),
    .ddr_ready           (ddr_ready),
    .ddr_addr            (ddr_addr),
    .ddr_write_data      (ddr_write_data),
    .ddr_byte_enable     (ddr_byte_enable),
    .ddr_write_req       (ddr_write_req),
    .ddr_read_req        (ddr_read_req),
    .ddr_read_data       (ddr_read_data),
    .ddr_read_data_valid (ddr_read_data_valid),
    .error               (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_addr = A0; m1_addr = A1;
    m0_write_data = D0; m1_write_data = D1;
    m0_byte_enable = 4'h3; m1_byte_enable = 4'hc;
    m0_write_req = 0; m0_read_req = 0; m1_write_req = 0; m1_read_req = 0;
    ddr_ready = 1'b1; ddr_read_data = '0; ddr_read_data_valid = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic issue_read(input logic id, input logic [26:2] addr, input logic [31:0] data);
    clear_inputs();
    if (id) begin m1_read_req = 1'b1; m1_addr = addr; end
    else    begin m0_read_req = 1'b1; m0_addr = addr; end
    @(negedge clk);
    chk("rd_ready", id ? m1_ready : m0_ready, 1);
    chk("rd_ddr_read_req", ddr_read_req, 1);
    chk("rd_ddr_addr", 32'(ddr_addr), 32'(addr));
    sb.push_back('{id: id, data: data});
    advance();
    clear_inputs();
  endtask

  task automatic do_return();
    exp_t e;
    if (sb.size() == 0) begin
      chk("ret_scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      ddr_read_data = e.data;
      ddr_read_data_valid = 1'b1;
      @(negedge clk);
      chk("ret_m0_valid", m0_read_data_valid, (e.id == 1'b0));
      chk("ret_m1_valid", m1_read_data_valid, (e.id == 1'b1));
      chk("ret_data", e.id ? m1_read_data : m0_read_data, e.data);
      advance();
      ddr_read_data_valid = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, A0};
    vecs[1] = '{0, 0, 1, 0, 0,  0, 0, 1, 0, A1};
    vecs[2] = '{1, 0, 1, 0, 0,  0, 0, 1, 0, A0};
    vecs[3] = '{1, 0, 1, 0, 1,  1, 0, 1, 0, A0};
    vecs[4] = '{1, 0, 1, 0, 1,  !Rr, Rr, 1, 0, Rr ? A1 : A0};
    vecs[5] = '{1, 0, 1, 0, 1,  1, 0, 1, 0, A0};
    vecs[6] = '{1, 0, 1, 0, 0,  0, 0, 1, 0, Rr ? A1 : A0};
    vecs[7] = '{0, 0, 1, 0, 1,  0, 1, 1, 0, A1};
    vecs[8] = '{1, 0, 0, 0, 1,  1, 0, 1, 0, A0};
    vecs[9] = '{1, 0, 1, 0, 1,  !Rr, Rr, 1, 0, Rr ? A1 : A0};

    do_reset();
    ddr_ready = 1'b0;
    @(negedge clk);
    chk("reset_ddr_write_req", ddr_write_req, 0);
    chk("reset_ddr_read_req", ddr_read_req, 0);
    chk("reset_m0_valid", m0_read_data_valid, 0);
    chk("reset_m1_valid", m1_read_data_valid, 0);
    chk("reset_error", error, 0);
    advance();

    // Write arbitration from reset
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      m0_write_req = vecs[i].m0_wr; m0_read_req = vecs[i].m0_rd;
      m1_write_req = vecs[i].m1_wr; m1_read_req = vecs[i].m1_rd;
      ddr_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_m0_ready", i), m0_ready, vecs[i].exp_r0);
      chk($sformatf("vec%0d_m1_ready", i), m1_ready, vecs[i].exp_r1);
      chk($sformatf("vec%0d_ddr_write_req", i), ddr_write_req, vecs[i].exp_wr);
      chk($sformatf("vec%0d_ddr_read_req", i), ddr_read_req, vecs[i].exp_rd);
      chk($sformatf("vec%0d_ddr_addr", i), 32'(ddr_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_ddr_wdata", i), ddr_write_data,
          (vecs[i].exp_addr == A1) ? D1 : D0);
      advance();
    end

    // Stall with both requesting: grant holds on master 0, no ready pulses
    clear_inputs();
    m0_write_req = 1; m1_write_req = 1; ddr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_m0_ready", i), m0_ready, 0);
      chk($sformatf("stall%0d_m1_ready", i), m1_ready, 0);
      chk($sformatf("stall%0d_ddr_addr", i), 32'(ddr_addr), 32'(A0));
      advance();
    end
    ddr_ready = 1;
    @(negedge clk);
    chk("stall_release_m0_ready", m0_ready, 1);
    chk("stall_release_m1_ready", m1_ready, 0);
    advance();
    clear_inputs();
    advance();

    // Single read and return
    issue_read(0, 25'h100, 32'hDEAD_BEEF);
    repeat (2) advance();
    do_return();

    // Interleaved reads, returns 5 cycles later
    issue_read(0, 25'h010, 32'hA000_0000);
    issue_read(1, 25'h020, 32'hA000_0001);
    issue_read(1, 25'h030, 32'hA000_0002);
    issue_read(0, 25'h040, 32'hA000_0003);
    repeat (5) advance();
    for (int i = 0; i < 4; i++) do_return();

    // Fill the ID FIFO
    for (int i = 0; i < 16; i++) issue_read(0, 25'(i), 32'hC000_0000 + i);
    m0_read_req = 1; m0_addr = 25'h3ff;
    @(negedge clk);
    chk("full_m0_ready", m0_ready, 0);
    chk("full_ddr_read_req", ddr_read_req, 0);
    advance();
    m1_write_req = 1;
    @(negedge clk);
    chk("full_m1_write_ready", m1_ready, 1);
    chk("full_ddr_write_req", ddr_write_req, 1);
    chk("full_m0_ready_blocked", m0_ready, 0);
    advance();
    m1_write_req = 0;
    // Return in the same cycle as a held read: the read must still wait
    e = sb.pop_front();
    ddr_read_data = e.data; ddr_read_data_valid = 1;
    @(negedge clk);
    chk("fullpop_m0_ready", m0_ready, 0);
    chk("fullpop_ddr_read_req", ddr_read_req, 0);
    chk("fullpop_m0_valid", m0_read_data_valid, (e.id == 1'b0));
    chk("fullpop_m1_valid", m1_read_data_valid, (e.id == 1'b1));
    advance();
    ddr_read_data_valid = 0;
    @(negedge clk);
    chk("afterpop_m0_ready", m0_ready, 1);
    chk("afterpop_ddr_read_req", ddr_read_req, 1);
    sb.push_back('{id: 1'b0, data: 32'hC000_00FF});
    advance();
    clear_inputs();
    while (sb.size() > 0) do_return();

    // Return with empty FIFO sets sticky error
    ddr_read_data = 32'h5555_AAAA; ddr_read_data_valid = 1;
    @(negedge clk);
    chk("empty_m0_valid", m0_read_data_valid, 0);
    chk("empty_m1_valid", m1_read_data_valid, 0);
    chk("empty_error_before", error, 0);
    advance();
    ddr_read_data_valid = 0;
    @(negedge clk);
    chk("error_set", error, 1);
    repeat (2) advance();
    @(negedge clk);
    chk("error_held", error, 1);
    reset_n = 1'b0;
    #1;
    chk("error_async_clear", error, 0);
    do_reset();
    @(negedge clk);
    chk("error_after_reset", error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
